// File: rtl/iomem_pkg.sv
// Shared types and default SoC address map for the picosoc iomem fabric.
package iomem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_ERR
  } state_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hFFFF_FFFF;

  // Slave 0 is the SPI flash config window; GPIO/RNG are single registers, RAM a 256-byte page
  localparam logic [31:0] SPIMEM_CFG_BASE = 32'h0200_0000;
  localparam logic [31:0] GPIO_BASE       = 32'h0300_0000;
  localparam logic [31:0] RNG_BASE        = 32'h0300_1000;
  localparam logic [31:0] RAM_BASE        = 32'h0300_2000;

  localparam logic [31:0] MASK_WORD16  = 32'hFFFF_FFF0;
  localparam logic [31:0] MASK_EXACT   = 32'hFFFF_FFFF;
  localparam logic [31:0] MASK_PAGE256 = 32'hFFFF_FF00;

  localparam logic [127:0] DEFAULT_BASE_ADDRS =
    {RAM_BASE, RNG_BASE, GPIO_BASE, SPIMEM_CFG_BASE};
  localparam logic [127:0] DEFAULT_ADDR_MASKS =
    {MASK_PAGE256, MASK_EXACT, MASK_EXACT, MASK_WORD16};

  function automatic int width_min1(input int n);
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/iomem_fabric_if.sv
// iomem bus bundle: master modport is the CPU/peripheral side, slave modport is the fabric.
interface iomem_fabric_if #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32
);

  logic                         m_valid;
  logic                         m_ready;
  logic [DATA_W/8-1:0]          m_wstrb;
  logic [ADDR_W-1:0]            m_addr;
  logic [DATA_W-1:0]            m_wdata;
  logic [DATA_W-1:0]            m_rdata;
  logic [NUM_SLAVES-1:0]        s_valid;
  logic [NUM_SLAVES-1:0]        s_ready;
  logic [DATA_W/8-1:0]          s_wstrb;
  logic [ADDR_W-1:0]            s_addr;
  logic [DATA_W-1:0]            s_wdata;
  logic [NUM_SLAVES*DATA_W-1:0] s_rdata;
  logic                         bus_err;
  logic [7:0]                   err_count;

  modport master (
    output m_valid, m_wstrb, m_addr, m_wdata, s_ready, s_rdata,
    input  m_ready, m_rdata, s_valid, s_wstrb, s_addr, s_wdata, bus_err, err_count
  );

  modport slave (
    input  m_valid, m_wstrb, m_addr, m_wdata, s_ready, s_rdata,
    output m_ready, m_rdata, s_valid, s_wstrb, s_addr, s_wdata, bus_err, err_count
  );

endinterface

// File: rtl/iomem_addr_decode.sv
// Combinational base/mask address match; the lowest matching slave index wins.
module iomem_addr_decode
  import iomem_pkg::*;
#(
  parameter int                           NUM_SLAVES = 4,
  parameter int                           ADDR_W     = 32,
  parameter int                           IDX_W      = 2,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] BASE_ADDRS = DEFAULT_BASE_ADDRS,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] ADDR_MASKS = DEFAULT_ADDR_MASKS
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_hit,
  output logic [IDX_W-1:0]  o_idx
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    o_hit = 1'b0;
    o_idx = '0;
    // Scan high to low so the lowest matching index is written last.
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((i_addr & ADDR_MASKS[i*ADDR_W +: ADDR_W]) ==
          (BASE_ADDRS[i*ADDR_W +: ADDR_W] & ADDR_MASKS[i*ADDR_W +: ADDR_W])) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/iomem_fabric.sv
// picosoc iomem interconnect: latched request, one-hot slave select, timeout and error response.
module iomem_fabric
  import iomem_pkg::*;
#(
  parameter int                           NUM_SLAVES     = 4,
  parameter int                           DATA_W         = 32,
  parameter int                           ADDR_W         = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] BASE_ADDRS     = DEFAULT_BASE_ADDRS,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] ADDR_MASKS     = DEFAULT_ADDR_MASKS,
  parameter int                           TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0]            ERR_DATA       = ERR_DATA_DEFAULT
) (
  input logic           clk_i,
  input logic           rst_i,
  iomem_fabric_if.slave bus
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int IDX_W   = width_min1($clog2(NUM_SLAVES));
  localparam int CNT_W   = width_min1($clog2(TIMEOUT_CYCLES + 1));
  localparam int TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  w_hit;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_accept;
  logic                  w_sel_ready;
  logic                  w_timeout;
  logic [DATA_W-1:0]     w_sel_rdata;
  logic [NUM_SLAVES-1:0] w_s_valid;

  logic [IDX_W-1:0]      r_idx;
  logic [ADDR_W-1:0]     r_s_addr;
  logic [DATA_W-1:0]     r_s_wdata;
  logic [STRB_W-1:0]     r_s_wstrb;
  logic [CNT_W-1:0]      r_wait_cnt;
  logic [DATA_W-1:0]     r_m_rdata;
  logic                  r_m_ready;
  logic                  r_bus_err;
  logic [7:0]            r_err_count;

  iomem_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .IDX_W      (IDX_W),
    .BASE_ADDRS (BASE_ADDRS),
    .ADDR_MASKS (ADDR_MASKS)
  ) u_decode (
    .i_addr (bus.m_addr),
    .o_hit  (w_hit),
    .o_idx  (w_idx)
  );

  // Responses are registered, so an error response is still on the bus after ERR returns to IDLE.
  assign w_accept    = bus.m_valid && !r_m_ready;
  assign w_sel_ready = bus.s_ready[r_idx];
  assign w_sel_rdata = bus.s_rdata[int'(r_idx)*DATA_W +: DATA_W];
  assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_wait_cnt == CNT_W'(TO_LAST));

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_valid   = '0;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_hit ? ST_WAIT : ST_ERR;
      ST_WAIT: begin
        w_s_valid[r_idx] = 1'b1;
        if (w_sel_ready)    w_state_nxt = ST_RESP;
        else if (w_timeout) w_state_nxt = ST_ERR;
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      ST_ERR:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_idx       <= '0;
      r_s_addr    <= '0;
      r_s_wdata   <= '0;
      r_s_wstrb   <= '0;
      r_wait_cnt  <= '0;
      r_m_rdata   <= '0;
      r_m_ready   <= 1'b0;
      r_bus_err   <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_m_ready <= 1'b0;
      r_bus_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_wait_cnt <= '0;
          if (w_accept) begin
            r_idx     <= w_idx;
            r_s_addr  <= bus.m_addr;
            r_s_wdata <= bus.m_wdata;
            r_s_wstrb <= bus.m_wstrb;
          end
        end
        ST_WAIT: begin
          r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          if (w_sel_ready) begin
            r_m_rdata <= w_sel_rdata;
            r_m_ready <= 1'b1;
          end
        end
        ST_ERR: begin
          r_m_rdata <= ERR_DATA;
          r_m_ready <= 1'b1;
          r_bus_err <= 1'b1;
          if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.m_ready   = r_m_ready;
  assign bus.m_rdata   = r_m_rdata;
  assign bus.s_valid   = w_s_valid;
  assign bus.s_addr    = r_s_addr;
  assign bus.s_wdata   = r_s_wdata;
  assign bus.s_wstrb   = r_s_wstrb;
  assign bus.bus_err   = r_bus_err;
  assign bus.err_count = r_err_count;

endmodule
